// File: rtl/spi_device_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : audipus_spi_pkg                                              |
// | Description : Shared constants for the SPI device router: FSM state        |
// |               encodings, err_status bit positions and synchroniser depth.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package audipus_spi_pkg;

  // Router FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ABORT  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // Bit positions inside err_status
  localparam int ERR_FRAME   = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_SELCHG  = 2;

  // Flop depth of every asynchronous-input synchroniser
  localparam int SYNC_STAGES = 2;

endpackage : audipus_spi_pkg
`default_nettype wire

// File: rtl/spi_device_router_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : spi_device_router_if                                         |
// | Description : Host-side SPI bus plus fanned-out device-side bus.           |
// |   spi_cs_n/spi_clk/spi_mosi : host SPI (async to clk)                      |
// |   dev_sel                   : device select code (async)                   |
// |   dev_cs_n/dev_clk/dev_mosi : routed device-side SPI                       |
// |   modport slave  : router view (host in, device out)                       |
// |   modport master : host/test view (host out, device in)                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface spi_device_router_if #(
  parameter int N_DEV = 4,
  parameter int SEL_W = 2
);
  logic             spi_cs_n;
  logic             spi_clk;
  logic             spi_mosi;
  logic [SEL_W-1:0] dev_sel;
  logic [N_DEV-1:0] dev_cs_n;
  logic             dev_clk;
  logic             dev_mosi;

  modport slave (
    input  spi_cs_n, spi_clk, spi_mosi, dev_sel,
    output dev_cs_n, dev_clk, dev_mosi
  );

  modport master (
    output spi_cs_n, spi_clk, spi_mosi, dev_sel,
    input  dev_cs_n, dev_clk, dev_mosi
  );
endinterface : spi_device_router_if
`default_nettype wire

// File: rtl/spi_device_router_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync2                                                        |
// | Description : 1-bit multi-flop synchroniser with a parameterised reset     |
// |               value, so idle-high signals (chip select) do not glitch low  |
// |               out of reset.                                                |
// |   clk, reset_n : system clock, async active-low reset                      |
// |   d            : asynchronous input                                        |
// |   q            : synchronised output                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync2
  import audipus_spi_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule : sync2
`default_nettype wire

// File: rtl/spi_device_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_device_router                                            |
// | Description : Routes one host SPI bus to N_DEV peripherals. The select     |
// |               code is latched only between frames; each frame is monitored |
// |               for bit count, framing error, timeout and select change.     |
// |   clk, reset_n : system clock (>= 8x SCLK), async active-low reset         |
// |   bus          : spi_device_router_if.slave (host SPI in, device SPI out)  |
// |   busy         : FSM not idle                                              |
// |   last_dev     : select code of the last completed frame                   |
// |   last_bits    : SCLK rising edges of the last frame (saturating at 255)   |
// |   err_status   : sticky [0] framing, [1] timeout, [2] select changed       |
// |   clr_err      : 1-cycle pulse, clears err_status (new errors win)         |
// | Optional      : SPI_ROUTER_STATS_EN adds per-device 8-bit frame counters   |
// |                 readable via stat_sel/stat_count, cleared by stat_rd_stb.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module spi_device_router
  import audipus_spi_pkg::*;
#(
  parameter int N_DEV       = 4,
  parameter int SEL_W       = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_device_router_if.slave bus,
  output logic             busy,
  output logic [SEL_W-1:0] last_dev,
  output logic [7:0]       last_bits,
  output logic [2:0]       err_status,
  input  logic             clr_err
`ifdef SPI_ROUTER_STATS_EN
  ,
  input  logic [SEL_W-1:0] stat_sel,
  input  logic             stat_rd_stb,
  output logic [7:0]       stat_count
`endif
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  // ---------------------------------------------------------------- sync
  logic             cs_s;
  logic             sclk_s;
  logic [SEL_W-1:0] sel_s;

  sync2 #(.INIT(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.spi_cs_n),
    .q       (cs_s)
  );

  sync2 #(.INIT(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.spi_clk),
    .q       (sclk_s)
  );

  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_sel_sync
    sync2 #(.INIT(1'b0)) u_sync_sel (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.dev_sel[gi]),
      .q       (sel_s[gi])
    );
  end

  // ---------------------------------------------------------------- state
  logic [1:0]       state_q,      state_d;
  logic [SEL_W-1:0] sel_q,        sel_d;
  logic [7:0]       bit_cnt_q,    bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,     to_cnt_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic [SEL_W-1:0] last_dev_q,   last_dev_d;
  logic [7:0]       last_bits_q,  last_bits_d;
  logic [2:0]       err_q,        err_d;
  logic [N_DEV-1:0] dev_cs_n_q,   dev_cs_n_d;
  logic             clk_en_q,     clk_en_d;
  logic             sclk_s_d_q;
  logic             sclk_rise;

  assign sclk_rise = sclk_s & ~sclk_s_d_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    settle_cnt_d = settle_cnt_q;
    last_dev_d   = last_dev_q;
    last_bits_d  = last_bits_q;
    // Clear is applied first so that an error raised this cycle survives it.
    err_d        = clr_err ? 3'b000 : err_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = sel_s;
        if (!cs_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end

      ST_ACTIVE: begin
        if (sclk_rise && (bit_cnt_q != 8'hFF)) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
        to_cnt_d = to_cnt_q + TO_W'(1);
        // sel_q is deliberately kept; only the anomaly is reported.
        if (sel_s != sel_q) begin
          err_d[ERR_SELCHG] = 1'b1;
        end
        if (cs_s) begin
          last_bits_d  = bit_cnt_q;
          last_dev_d   = sel_q;
          if (bit_cnt_q[2:0] != 3'd0) begin
            err_d[ERR_FRAME] = 1'b1;
          end
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end else if ((TIMEOUT_CYC != 0) && (to_cnt_d == TO_W'(TIMEOUT_CYC))) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (cs_s) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        // A quick re-select resumes with the previously latched device.
        if (!cs_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (settle_cnt_q == 8'(SETTLE_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Device-side selects are registered from the next state so they
    // follow spi_cs_n by exactly the synchroniser depth plus one flop.
    clk_en_d = (state_d == ST_ACTIVE);
    for (int i = 0; i < N_DEV; i++) begin
      dev_cs_n_d[i] = ~(clk_en_d && (sel_d == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      settle_cnt_q <= '0;
      last_dev_q   <= '0;
      last_bits_q  <= '0;
      err_q        <= '0;
      dev_cs_n_q   <= '1;
      clk_en_q     <= 1'b0;
      sclk_s_d_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      last_dev_q   <= last_dev_d;
      last_bits_q  <= last_bits_d;
      err_q        <= err_d;
      dev_cs_n_q   <= dev_cs_n_d;
      clk_en_q     <= clk_en_d;
      sclk_s_d_q   <= sclk_s;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.dev_cs_n = dev_cs_n_q;
  assign bus.dev_clk  = bus.spi_clk & clk_en_q;
  assign bus.dev_mosi = bus.spi_mosi;
  assign busy         = (state_q != ST_IDLE);
  assign last_dev     = last_dev_q;
  assign last_bits    = last_bits_q;
  assign err_status   = err_q;

`ifdef SPI_ROUTER_STATS_EN
  // ---------------------------------------------------------------- stats
  logic [N_DEV-1:0][7:0] frame_cnt_q, frame_cnt_d;
  logic                  frame_done;

  assign frame_done = (state_q == ST_ACTIVE) && (state_d == ST_SETTLE);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stat_count  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (stat_rd_stb && (stat_sel == SEL_W'(i))) begin
        // Read-clear and a completing frame together leave one counted frame.
        frame_cnt_d[i] = (frame_done && (sel_q == SEL_W'(i))) ? 8'd1 : 8'd0;
      end else if (frame_done && (sel_q == SEL_W'(i))) begin
        frame_cnt_d[i] = frame_cnt_q[i] + 8'd1;
      end
      if (stat_sel == SEL_W'(i)) begin
        stat_count = frame_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`endif

endmodule : spi_device_router
`default_nettype wire
